// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - debounced pushbutton capture of ALU operands A/B and opcode
// Optional opcode legality check enabled by defining ALU_LOADER_OPCHECK_EN.
module alu_operand_loader #(
    parameter int NBITS     = 8,
    parameter int COD_OP    = 6,
    parameter int DB_CYCLES = 4,
    parameter int DB_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        pulsador,
    input  logic [NBITS-1:0]  entrada,
    output logic [NBITS-1:0]  inA,
    output logic [NBITS-1:0]  inB,
    output logic [COD_OP-1:0] cod_op,
    output logic [2:0]        loaded,
    output logic              valid,
    output logic              op_err
);

    generate
        if (COD_OP > NBITS) begin : g_bad_codop
            $error("alu_operand_loader: COD_OP must not exceed NBITS");
        end
        if (DB_CYCLES < 2 || (2 ** DB_W) <= DB_CYCLES) begin : g_bad_db
            $error("alu_operand_loader: DB_CYCLES must be >= 2 and fit in DB_W bits");
        end
    endgenerate

    logic [2:0]        r_sync1;
    logic [2:0]        r_sync2;
    logic [2:0]        r_db;
    logic [2:0]        r_db_prev;
    logic [DB_W-1:0]   r_cnt [3];
    logic [NBITS-1:0]  r_inA;
    logic [NBITS-1:0]  r_inB;
    logic [COD_OP-1:0] r_cod_op;
    logic [2:0]        r_loaded;
    logic              r_valid;

    logic [2:0]        w_load;
    logic              w_op_ok;
    logic [2:0]        w_loaded_next;

    // Three identical channels: 2-flop sync, stability counter, rising-edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_db      <= '0;
            r_db_prev <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= pulsador;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign w_load = r_db & ~r_db_prev;

`ifdef ALU_LOADER_OPCHECK_EN
    generate
        if (COD_OP != 6) begin : g_bad_opcheck
            $error("alu_operand_loader: opcode check needs COD_OP == 6");
        end
    endgenerate

    logic r_op_err;

    always_comb begin
        w_op_ok = 1'b0;
        case (entrada[5:0])
            6'b100000, 6'b100010, 6'b100100, 6'b100101,
            6'b100110, 6'b000011, 6'b000010, 6'b100111: w_op_ok = 1'b1;
            default:                                    w_op_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_err <= 1'b0;
        end else begin
            r_op_err <= w_load[2] & ~w_op_ok;
        end
    end

    assign op_err = r_op_err;
`else
    assign w_op_ok = 1'b1;
    assign op_err  = 1'b0;
`endif

    assign w_loaded_next = r_loaded | {w_load[2] & w_op_ok, w_load[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inA    <= '0;
            r_inB    <= '0;
            r_cod_op <= '0;
            r_loaded <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_load[0]) begin
                r_inA <= entrada;
            end
            if (w_load[1]) begin
                r_inB <= entrada;
            end
            if (w_load[2] && w_op_ok) begin
                r_cod_op <= entrada[COD_OP-1:0];
            end
            r_loaded <= w_loaded_next;
            r_valid  <= &w_loaded_next;
        end
    end

    assign inA    = r_inA;
    assign inB    = r_inB;
    assign cod_op = r_cod_op;
    assign loaded = r_loaded;
    assign valid  = r_valid;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - scoreboard bench for alu_operand_loader
module tb_alu_operand_loader;

    localparam int NBITS  = 8;
    localparam int COD_OP = 6;
    localparam int DB     = 4;
    localparam int DB_W   = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [2:0]        pulsador = '0;
    logic [NBITS-1:0]  entrada = '0;
    logic [NBITS-1:0]  inA;
    logic [NBITS-1:0]  inB;
    logic [COD_OP-1:0] cod_op;
    logic [2:0]        loaded;
    logic              valid;
    logic              op_err;

    alu_operand_loader #(
        .NBITS(NBITS), .COD_OP(COD_OP), .DB_CYCLES(DB), .DB_W(DB_W)
    ) dut (
        .clk(clk), .reset(reset), .pulsador(pulsador), .entrada(entrada),
        .inA(inA), .inB(inB), .cod_op(cod_op), .loaded(loaded),
        .valid(valid), .op_err(op_err)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    typedef struct {
        int          c;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [5:0]  op;
        logic [2:0]  ld;
        logic        vld;
        logic        err;
    } exp_t;

    exp_t q[$];
    logic [7:0] m_a  = '0;
    logic [7:0] m_b  = '0;
    logic [5:0] m_op = '0;
    logic [2:0] m_ld = '0;
    int n_pass = 0;
    int n_tot  = 0;

    function automatic void check(string nm, logic [31:0] got, logic [31:0] expv);
        n_tot++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, expv, cyc);
    endfunction

    function automatic logic legal(logic [5:0] op);
`ifdef ALU_LOADER_OPCHECK_EN
        logic [5:0] codes [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};
        foreach (codes[i]) if (codes[i] == op) return 1'b1;
        return 1'b0;
`else
        return (op == op);
`endif
    endfunction

    function automatic logic [7:0] alu(logic [5:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h03:   return 8'($signed(a) >>> b);
            6'h02:   return a >> b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    // Monitor: any visible output change must match the next scoreboard entry.
    logic [26:0] prev_sig = '0;
    logic [26:0] cur_sig;
    exp_t        e_mon;
    always @(negedge clk) begin
        cur_sig = {inA, inB, cod_op, loaded, valid, op_err};
        if (rst_q) begin
            check("reset_state", 32'(cur_sig), 32'd0);
        end else if (cur_sig !== prev_sig) begin
            if (q.size() == 0) begin
                check("unexpected_update", 32'(cur_sig), 32'(prev_sig));
            end else begin
                e_mon = q.pop_front();
                check("load_edge", cyc, e_mon.c);
                check("inA", 32'(inA), 32'(e_mon.a));
                check("inB", 32'(inB), 32'(e_mon.b));
                check("cod_op", 32'(cod_op), 32'(e_mon.op));
                check("loaded", 32'(loaded), 32'(e_mon.ld));
                check("valid", 32'(valid), 32'(e_mon.vld));
                check("op_err", 32'(op_err), 32'(e_mon.err));
            end
        end
        prev_sig = cur_sig;
    end

    // Apply a model load of mask m with value v, first sampled at edge k+1.
    task automatic expect_load(input logic [2:0] m, input logic [7:0] v, input int k);
        exp_t e;
        logic acc;
        acc = legal(v[5:0]);
        if (m[0]) begin m_a = v; m_ld[0] = 1'b1; end
        if (m[1]) begin m_b = v; m_ld[1] = 1'b1; end
        if (m[2] && acc) begin m_op = v[5:0]; m_ld[2] = 1'b1; end
        e.c = k + DB + 3; e.a = m_a; e.b = m_b; e.op = m_op;
        e.ld = m_ld; e.vld = &m_ld; e.err = m[2] & ~acc;
        q.push_back(e);
        if (e.err) begin
            e.c = e.c + 1; e.err = 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic press(input logic [2:0] m, input logic [7:0] v, input int hold);
        entrada  = v;
        pulsador = m;
        expect_load(m, v, cyc);
        repeat (hold) @(negedge clk);
        pulsador = '0;
        repeat (DB + 6) @(negedge clk);
    endtask

    task automatic glitch(input logic [2:0] m, input int g);
        pulsador = m;
        repeat (g) @(negedge clk);
        pulsador = '0;
        repeat (DB + 6) @(negedge clk);
    endtask

    function automatic logic changes(logic [2:0] m, logic [7:0] v);
        if (m[0] && v == m_a) return 1'b0;
        if (m[1] && v == m_b) return 1'b0;
        if (m[2] && legal(v[5:0]) && v[5:0] == m_op) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        logic [2:0] m;
        logic [7:0] v;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        press(3'b001, 8'h0F, 10);
        glitch(3'b010, DB - 1);
        press(3'b010, 8'hA5, 6);
        press(3'b001, 8'h05, 5);
        press(3'b010, 8'h03, 5);
        press(3'b100, 8'h20, 5);
        check("alu_add", 32'(alu(cod_op, inA, inB)), 32'h08);
        check("alu_model", 32'(alu(cod_op, inA, inB)), 32'(alu(m_op, m_a, m_b)));
        press(3'b011, 8'h3C, 6);

        // Reset two cycles into a press, button still held on release.
        entrada  = 8'h77;
        pulsador = 3'b001;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_a = '0; m_b = '0; m_op = '0; m_ld = '0;
        expect_load(3'b001, 8'h77, cyc);
        repeat (6) @(negedge clk);
        pulsador = '0;
        repeat (DB + 6) @(negedge clk);

        press(3'b100, 8'h3F, 5);
        press(3'b100, 8'h26, 5);

        for (int i = 0; i < 30; i++) begin
            m = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 3) == 0) begin
                glitch(m, $urandom_range(1, DB - 1));
            end else begin
                v = 8'($urandom);
                while (!changes(m, v)) v = 8'($urandom);
                press(m, v, $urandom_range(DB, DB + 4));
            end
        end

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Front end that produces the ALU's operands from the board controls. It captures the switch bus into operand A, operand B and the opcode on debounced presses of three pushbuttons.
- Outputs drive the ALU's operando_A, operando_B and cod_operacion inputs directly and replace the unregistered capture logic in the board top level.
- Also reports which fields hold user-loaded data, and when all three are loaded.

Parameters:
- NBITS, 8, width of switch bus and of operands A/B.
- COD_OP, 6, opcode width; constraint COD_OP <= NBITS.
- DB_CYCLES, 4, consecutive stable synchronized samples required before the debounced level changes; must be >= 2.
- DB_W, 3, debounce counter width; constraint 2^DB_W > DB_CYCLES.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pulsador  in  3  raw async buttons; bit0 loads A, bit1 loads B, bit2 loads opcode.
- entrada  in  NBITS  switch bus, sampled directly (treated as static when a load fires).
- inA  out  NBITS  operand A register.
- inB  out  NBITS  operand B register.
- cod_op  out  COD_OP  opcode register, loaded from entrada[COD_OP-1:0].
- loaded  out  3  sticky per-field loaded flags, same bit mapping as pulsador.
- valid  out  1  high when loaded == 3'b111.
- op_err  out  1  one-cycle pulse on a rejected opcode load (optional feature only).

Behaviour:
- Reset (synchronous, reset=1 at a clk edge): inA, inB, cod_op, loaded, valid, op_err all 0. Synchronizers, debounced levels, edge-detect history and counters also 0. Reset mid-debounce discards the partial count.
- Per-button pipeline, three independent identical channels:
  - Synchronizer: 2-flop synchronizer, output s.
  - Debounce counter: if s == db, counter <= 0. Else if counter == DB_CYCLES-1, db <= s and counter <= 0. Else counter += 1.
  - Edge detect: db_prev <= db; load_i = db & ~db_prev.
- Load timing: for a press first sampled at edge 1 and held, the target register updates at edge DB_CYCLES+3. With default DB_CYCLES=4, that is edge 7.
- Release is debounced the same way and causes no load.
- Glitches: any high or low run shorter than DB_CYCLES synchronized samples is ignored. A held button produces exactly one load.
- Button held through reset deassertion: s rises after reset, so one load occurs DB_CYCLES+3 edges after reset deasserts.
- Load action, same edge as the load:
  - load_0: inA <= entrada; loaded[0] <= 1.
  - load_1: inB <= entrada; loaded[1] <= 1.
  - load_2: cod_op <= entrada[COD_OP-1:0]; loaded[2] <= 1.
- Simultaneous loads: each fired field captures the same entrada value in the same cycle.
- Reload: an already-loaded field overwrites its value; its flag stays 1.
- valid: registered, updated on the same edge as loaded; equals &loaded_next. Once high it stays high until reset.
- No other state. Flags are cleared only by reset.

Optional Feature:
- Macro: ALU_LOADER_OPCHECK_EN.
- Defined: a load_2 is accepted only if entrada[5:0] is one of:
  - 100000 ADD
  - 100010 SUB
  - 100100 AND
  - 100101 OR
  - 100110 XOR
  - 000011 SRA
  - 000010 SRL
  - 100111 NOR
- Defined, illegal code: cod_op and loaded[2] are unchanged, and op_err=1 for exactly the next cycle (registered, same edge the load would have occurred).
- Defined: requires COD_OP == 6, checked by elaboration assertion.
- Not defined: every load_2 is accepted and op_err is tied to 0.

Test Plan:
- Reset, then entrada=8'h0F and pulsador=3'b001 held 10 cycles -> inA=8'h0F at edge 7, loaded=3'b001, valid=0, inB=0, cod_op=0.
- Glitch: pulsador[1] high for 3 cycles (DB_CYCLES=4) -> no change to inB or loaded; then held 6 cycles with entrada=8'hA5 -> inB=8'hA5, exactly one load.
- Sequence: A=8'h05, B=8'h03, op=6'b100000 loaded via separate presses -> valid rises on the edge of the opcode load; the reference-model ALU result is 8'h08.
- Simultaneous: pulsador=3'b011 with entrada=8'h3C -> inA=inB=8'h3C on the same edge, loaded=3'b011.
- Reset mid-debounce: assert reset 2 cycles into a pulsador[0] press, release reset with the button still held -> inA=0 at reset release, inA=entrada 7 edges after reset deasserts.
- With ALU_LOADER_OPCHECK_EN: opcode press with entrada=8'h3F -> cod_op unchanged, loaded[2]=0, op_err single-cycle pulse. Then entrada=8'h26 -> cod_op=6'b100110, op_err=0.
